// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: requester handshake and regfile access bus for regfile_arbiter
interface regfile_arbiter_if #(parameter int NREQ = 2, parameter int AW = 32, parameter int DW = 32);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] req_rw;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [DW-1:0] rdata;
  logic err;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wdata;
  logic rf_rw;
  logic [DW-1:0] rf_rdata;
  modport slave (
    input req, req_rw, req_addr, req_wdata, rf_rdata,
    output gnt, rvalid, rdata, err, rf_addr, rf_wdata, rf_rw
  );
  modport master (
    output req, req_rw, req_addr, req_wdata, rf_rdata,
    input gnt, rvalid, rdata, err, rf_addr, rf_wdata, rf_rw
  );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin arbiter running one regfile read or write per grant
module regfile_arbiter #(
  parameter int NREQ = 2,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NREGS = 3
) (
  input logic ACLK,
  input logic ARST,
  regfile_arbiter_if.slave bus
);
  localparam int LW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  state_t state;
  logic [LW-1:0] last, nxt;
  logic oor;
  logic [AW-1:0] addr_n;
  logic [DW-1:0] wdata_n;
  logic rw_n, oor_n;
  // descending scan so the requester closest after last wins
  always_comb begin
    nxt = last;
    for (int i = NREQ; i >= 1; i--)
      if (bus.req[(int'(last) + i) % NREQ]) nxt = LW'((int'(last) + i) % NREQ);
  end
  assign addr_n = bus.req_addr[nxt*AW +: AW];
  assign wdata_n = bus.req_wdata[nxt*DW +: DW];
  assign rw_n = bus.req_rw[nxt];
  assign oor_n = addr_n >= AW'(NREGS);
  // last doubles as the current winner while a transaction is in flight
  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state <= IDLE;
      last <= LW'(NREQ - 1);
      oor <= 1'b0;
      bus.gnt <= '0;
      bus.rvalid <= '0;
      bus.rdata <= '0;
      bus.err <= 1'b0;
      bus.rf_addr <= '0;
      bus.rf_wdata <= '0;
      bus.rf_rw <= 1'b0;
    end else begin
      bus.gnt <= '0;
      bus.rvalid <= '0;
      case (state)
        IDLE: if (|bus.req) begin
          state <= ACCESS;
          last <= nxt;
          oor <= oor_n;
          bus.gnt <= NREQ'(1) << nxt;
          bus.rf_addr <= addr_n;
          bus.rf_wdata <= wdata_n;
          bus.rf_rw <= rw_n & ~oor_n;
        end
        ACCESS: begin
          bus.rf_rw <= 1'b0;
          state <= bus.rf_rw ? IDLE : RDATA;
        end
        RDATA: begin
          state <= IDLE;
          bus.rvalid <= NREQ'(1) << last;
          bus.rdata <= oor ? '0 : bus.rf_rdata;
          bus.err <= oor;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: scoreboard bench with a behavioural 3-entry regfile behind the arbiter
module tb_regfile_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int rv_cnt = 0;
  int g1_cnt = 0;
  int l0, l1, k, rv_before, g1_before;
  logic [31:0] regs [3];
  logic [31:0] shadow [3];
  typedef struct {int who; logic [31:0] data; logic e; int due;} item_t;
  item_t sb [$];
  int order [$];
  int gcyc [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  regfile_arbiter_if #(.NREQ(2), .AW(32), .DW(32)) bus ();
  regfile_arbiter #(.NREQ(2), .AW(32), .DW(32), .NREGS(3)) dut (.ACLK(clk), .ARST(rst), .bus(bus));
  // regfile: write at the edge, data_out registered one cycle after the address
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) regs[i] <= 32'h0;
      bus.rf_rdata <= 32'h0;
    end else begin
      if (bus.rf_rw && bus.rf_addr < 3) regs[bus.rf_addr[1:0]] <= bus.rf_wdata;
      bus.rf_rdata <= (bus.rf_addr < 3) ? regs[bus.rf_addr[1:0]] : 32'h0;
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    item_t it;
    if (!$onehot0(bus.gnt)) chk("gnt_onehot0", bus.gnt, 0);
    if (bus.rf_rw && !(|bus.gnt)) chk("rf_rw_stray", bus.rf_rw, 0);
    if (bus.gnt[1]) g1_cnt <= g1_cnt + 1;
    if (|bus.rvalid) begin
      rv_cnt <= rv_cnt + 1;
      if (sb.size() == 0) chk("rvalid_spurious", bus.rvalid, 0);
      else begin
        it = sb.pop_front();
        chk("rvalid_who", bus.rvalid, 64'(1) << it.who);
        chk("rdata", bus.rdata, it.data);
        chk("err", bus.err, it.e);
        chk("rvalid_cycle", cyc, it.due);
      end
    end
  end
  // one requester: hold fields with req high until n grants, scoring each accepted transaction
  task automatic run(input int i, input logic rw, input logic [31:0] addr, input logic [31:0] wd, input int n, output int l);
    int w;
    @(posedge clk);
    #1;
    bus.req_rw[i] = rw;
    bus.req_addr[i*32 +: 32] = addr;
    bus.req_wdata[i*32 +: 32] = wd;
    bus.req[i] = 1'b1;
    l = -1;
    for (int g = 0; g < n; g++) begin
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (w < 30 && !bus.gnt[i]);
      if (!bus.gnt[i]) begin
        chk($sformatf("gnt_timeout_r%0d", i), 0, 1);
        break;
      end
      if (g == 0) l = w;
      order.push_back(i);
      gcyc.push_back(cyc);
      chk("gnt_vec", bus.gnt, 64'(1) << i);
      chk("rf_addr", bus.rf_addr, addr);
      chk("rf_rw", bus.rf_rw, rw && addr < 3);
      if (addr >= 3) sb.push_back('{who: i, data: 32'h0, e: 1'b1, due: cyc + 2});
      else if (!rw) sb.push_back('{who: i, data: shadow[addr[1:0]], e: 1'b0, due: cyc + 2});
      else begin
        shadow[addr[1:0]] = wd;
        chk("rf_wdata", bus.rf_wdata, wd);
      end
    end
    bus.req[i] = 1'b0;
  endtask
  task automatic check_rotation(input string tag, input int spacing);
    for (int j = 1; j < order.size(); j++) begin
      chk({tag, "_alt"}, order[j] != order[j-1], 1);
      chk({tag, "_spacing"}, gcyc[j] - gcyc[j-1], spacing);
    end
    order.delete();
    gcyc.delete();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.req = '0;
    bus.req_rw = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 3; i++) shadow[i] = 32'h0;
    fork
      run(0, 1'b0, 32'd0, 32'h0, 1, l0);
      run(1, 1'b0, 32'd0, 32'h0, 1, l1);
      begin
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          chk("rst_gnt", bus.gnt, 0);
          chk("rst_rvalid", bus.rvalid, 0);
          chk("rst_rf_rw", bus.rf_rw, 0);
          chk("rst_rdata", bus.rdata, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join
    chk("rst_first_r0", order[0], 0);
    chk("rst_second_r1", order[1], 1);
    order.delete();
    gcyc.delete();
    repeat (4) @(negedge clk);
    run(0, 1'b1, 32'd1, 32'hDEAD_BEEF, 1, l0);
    chk("wr_gnt_latency", l0, 2);
    @(negedge clk);
    chk("wr_r1", regs[1], 32'hDEAD_BEEF);
    run(0, 1'b0, 32'd1, 32'h0, 1, l0);
    chk("rd_gnt_latency", l0, 2);
    run(0, 1'b1, 32'd0, 32'hA5A5_0000, 1, l0);
    run(1, 1'b1, 32'd2, 32'h0BAD_F00D, 1, l1);
    repeat (4) @(negedge clk);
    order.delete();
    gcyc.delete();
    fork
      run(0, 1'b0, 32'd0, 32'h0, 3, l0);
      run(1, 1'b0, 32'd2, 32'h0, 3, l1);
    join
    chk("rr_rd_count", order.size(), 6);
    check_rotation("rr_rd", 3);
    repeat (4) @(negedge clk);
    fork
      run(0, 1'b1, 32'd0, 32'h1111_0000, 2, l0);
      run(1, 1'b1, 32'd2, 32'h2222_0002, 2, l1);
    join
    chk("rr_wr_count", order.size(), 4);
    check_rotation("rr_wr", 2);
    repeat (2) @(negedge clk);
    chk("rr_wr_r0", regs[0], 32'h1111_0000);
    chk("rr_wr_r2", regs[2], 32'h2222_0002);
    repeat (4) @(negedge clk);
    run(1, 1'b1, 32'd3, 32'h1234_5678, 1, l1);
    run(0, 1'b0, 32'd7, 32'h0, 1, l0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("oor_r%0d", i), regs[i], shadow[i]);
    rv_before = rv_cnt;
    @(posedge clk);
    #1;
    bus.req_rw[0] = 1'b0;
    bus.req_addr[31:0] = 32'd1;
    bus.req[0] = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (k < 30 && !bus.gnt[0]);
    chk("midrst_gnt", bus.gnt, 1);
    bus.req[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) shadow[i] = 32'h0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_no_rvalid", rv_cnt - rv_before, 0);
    run(0, 1'b0, 32'd1, 32'h0, 1, l0);
    chk("midrst_rd_latency", l0, 2);
    repeat (4) @(negedge clk);
    run(1, 1'b0, 32'd0, 32'h0, 1, l1);
    repeat (4) @(negedge clk);
    g1_before = g1_cnt;
    fork
      run(0, 1'b0, 32'd2, 32'h0, 1, l0);
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (k < 30 && !bus.gnt[0]);
        @(posedge clk);
        #1 bus.req[1] = 1'b1;
        @(negedge clk);
        bus.req[1] = 1'b0;
      end
    join
    chk("wrap_latency", l0, 2);
    repeat (6) @(negedge clk);
    chk("withdraw_no_gnt1", g1_cnt - g1_before, 0);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Round-robin arbiter and access sequencer for the single-port `regfile` that sits behind the AMBA adder. It shares that register file between NREQ requesters, for example the bus-side slave and the adder writeback path. Each requester gets one complete read or write transaction per grant. The block drives the regfile `addr_in`/`data_in`/`rw` inputs, captures `data_out` for reads, and returns the data to the granted requester with a valid strobe.

## Interface
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width
- DW, 32, data width
- NREGS, 3, implemented registers; legal addresses are 0..NREGS-1
- ACLK  in  1  clock; all logic on the rising edge
- ARST  in  1  reset; synchronous, active-high
- req  in  NREQ  per-requester transaction request
- req_rw  in  NREQ  per-requester direction (0 read, 1 write)
- req_addr  in  NREQ*AW  per-requester address, packed, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  per-requester write data, packed
- gnt  out  NREQ  one-hot, 1-cycle pulse: transaction accepted and driven to the regfile
- rvalid  out  NREQ  one-hot, 1-cycle pulse: `rdata`/`err` valid for that requester
- rdata  out  DW  read return data
- err  out  1  address out of range; qualified by `rvalid`
- rf_addr  out  AW  to regfile `addr_in`
- rf_wdata  out  DW  to regfile `data_in`
- rf_rw  out  1  to regfile `rw` (0 read, 1 write)
- rf_rdata  in  DW  from regfile `data_out`; valid the cycle after `rf_addr` is presented

## Operation
- FSM states: IDLE, ACCESS, RDATA.
- IDLE:
  - With no request, stay in IDLE.
  - With any `req` bit set, pick the winner round-robin. Search starts at the requester after `last`, wrapping at NREQ.
  - Register the winner's addr, wdata and rw into `rf_*`. Set `last` = winner and go to ACCESS.
- ACCESS (1 cycle):
  - `gnt[winner]`=1.
  - Write with a legal address: `rf_rw`=1, and the regfile captures at the end of this cycle. The arbiter then returns to IDLE. No `rvalid` is issued for writes.
  - Read: `rf_rw`=0, go to RDATA.
  - Out-of-range address (addr ≥ NREGS): `rf_rw` is forced to 0 for both reads and writes, so no write occurs. The FSM goes to RDATA and the error is flagged.
- RDATA (1 cycle):
  - Capture `rf_rdata` into `rdata` with `err`=0. For an out-of-range access, `rdata`=0 and `err`=1.
  - `rvalid[winner]` pulses in the following cycle, while the FSM is back in IDLE.
- IDLE may accept a new request in the same cycle that `rvalid` is pulsing.
- Requester rules:
  - Hold `req`, `req_rw`, `req_addr` and `req_wdata` stable from assertion until `gnt` is seen.
  - After `gnt`, a requester may change its fields. `req` high in a later IDLE sample is a new transaction.
  - Dropping `req` before `gnt` withdraws the request. This is legal only while the FSM is in IDLE and that requester was not selected.
- Only one transaction is outstanding at a time. `rf_*` hold their last values outside ACCESS, except that `rf_rw` returns to 0 on leaving ACCESS.
- Reset values: state IDLE, `last`=NREQ-1 (requester 0 has first priority), `gnt`=0, `rvalid`=0, `rdata`=0, `err`=0, `rf_addr`=0, `rf_wdata`=0, `rf_rw`=0.

## Timing
- Request sampled in IDLE at cycle c. `gnt` is high in c+1, and a write lands in the regfile at the end of c+1.
- A read's `rvalid` is high in c+3.
- Throughput:
  - Back-to-back writes: one every 2 cycles.
  - Back-to-back reads: one every 3 cycles.
- Simultaneous requests: exactly one `gnt` per transaction. Requesters that keep `req` asserted are served strictly in rotation, with no starvation.
- `ARST` asserted in any state: next cycle is IDLE with all outputs at reset values.
  - A pending read is dropped, so its `rvalid` never fires.
  - A write is lost unless `ARST` was sampled after the ACCESS edge.
- `ARST` has priority over any request in the same cycle.
- No combinational path from `req*` inputs to any output.

## Test plan
- Reset: hold ARST 2 cycles with `req`=2'b11 → `gnt`=0, `rvalid`=0, `rf_rw`=0, `rdata`=0 throughout. After release, requester 0 is granted first.
- Single write then read, requester 0:
  - Write addr 1, data 0xDEADBEEF → `gnt[0]` at c+1, `rf_rw`=1 for one cycle, regfile r1=0xDEADBEEF.
  - Read addr 1 → `rvalid[0]` 3 cycles after the request, `rdata`=0xDEADBEEF, `err`=0.
- Contention: both requesters continuously request reads of addr 0 and 2 → grants alternate 0,1,0,1, and each `rvalid` matches its requester and address.
- Out of range: requester 1 writes addr 3, data 0x12345678 → `rf_rw` stays 0, r0..r2 unchanged, `rvalid[1]` with `err`=1 and `rdata`=0.
- Reset mid-read: assert ARST during RDATA → no `rvalid`, state IDLE. A subsequent read of addr 1 returns 0, the regfile's reset value.
- Withdrawal and wrap: requester 1 granted last, then only requester 0 requests → requester 0 is granted immediately. A request pulse from 1 dropped before selection yields no `gnt[1]`.
